// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: ALU control codes, FSM state type and shift-op helper for seq_alu.
package seq_alu_pkg;
  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_NOR  = 4'b0100;
  localparam logic [3:0] CTL_SLTU = 4'b0101;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SLL  = 4'b1000;
  localparam logic [3:0] CTL_SRL  = 4'b1001;
  localparam logic [3:0] CTL_SRA  = 4'b1011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t;

  function automatic logic is_shift(input logic [3:0] c);
    return c == CTL_SLL || c == CTL_SRL || c == CTL_SRA;
  endfunction
endpackage

// File: rtl/seq_alu_core.sv
// alu_core: single-cycle combinational logic/arithmetic ops; shifts and unknown codes give 0.
module alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb
    y = ctl == CTL_AND  ? a & b :
        ctl == CTL_OR   ? a | b :
        ctl == CTL_ADD  ? a + b :
        ctl == CTL_XOR  ? a ^ b :
        ctl == CTL_NOR  ? ~(a | b) :
        ctl == CTL_SLTU ? WIDTH'(a < b) :
        ctl == CTL_SUB  ? a - b :
        ctl == CTL_SLT  ? WIDTH'($signed(a) < $signed(b)) : '0;
endmodule

// File: rtl/seq_alu.sv
// seq_alu: valid/ready multi-cycle EX unit; iterative 1-bit/cycle shifter, or a
// single-cycle barrel shifter when SEQ_ALU_BARREL_EN is defined.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Ctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);
  alu_state_t state, state_n;
  logic [WIDTH-1:0] core_y, res_n;
  logic accept;

  alu_core #(.WIDTH(WIDTH)) u_core (.ctl(Ctl), .a(A), .b(B), .y(core_y));

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;

`ifdef SEQ_ALU_BARREL_EN
  logic signed [WIDTH-1:0] sra_v;
  assign sra_v = $signed(B) >>> Shamt;
  always_comb
    res_n = Ctl == CTL_SLL ? B << Shamt :
            Ctl == CTL_SRL ? B >> Shamt :
            Ctl == CTL_SRA ? sra_v : core_y;
  always_comb
    state_n = state == IDLE ? (accept ? DONE : IDLE) :
              state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Result <= '0;
      Zero   <= 1'b0;
    end else if (accept) begin
      Result <= res_n;
      Zero   <= res_n == '0;
    end
`else
  logic [WIDTH-1:0] work, work_n;
  logic [SHW-1:0] cnt;
  logic [3:0] sctl;
  logic start_shift;
  assign start_shift = accept && is_shift(Ctl) && Shamt != '0;
  // a zero-amount shift passes B straight through with single-cycle latency
  always_comb res_n = is_shift(Ctl) ? B : core_y;
  always_comb
    work_n = sctl == CTL_SLL ? {work[WIDTH-2:0], 1'b0} :
             sctl == CTL_SRA ? {work[WIDTH-1], work[WIDTH-1:1]} :
                               {1'b0, work[WIDTH-1:1]};
  always_comb
    state_n = state == IDLE  ? (start_shift ? SHIFT : accept ? DONE : IDLE) :
              state == SHIFT ? (cnt == SHW'(1) ? DONE : SHIFT) :
                               (out_ready ? IDLE : DONE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Result <= '0;
      Zero   <= 1'b0;
      work   <= '0;
      cnt    <= '0;
      sctl   <= '0;
    end else if (start_shift) begin
      work <= B;
      cnt  <= Shamt;
      sctl <= Ctl;
    end else if (accept) begin
      Result <= res_n;
      Zero   <= res_n == '0;
    end else if (state == SHIFT) begin
      work <= work_n;
      cnt  <= cnt - SHW'(1);
      if (cnt == SHW'(1)) begin
        Result <= work_n;
        Zero   <= work_n == '0;
      end
    end
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven, hand-sequenced and random checks of seq_alu against a reference model.
module tb_seq_alu;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, Zero;
  logic [3:0] Ctl = 0;
  logic [31:0] A = 0, B = 0, Result;
  logic [4:0] Shamt = 0;
  int errs = 0, checks = 0;

`ifdef SEQ_ALU_BARREL_EN
  localparam bit BARREL = 1;
`else
  localparam bit BARREL = 0;
`endif

  seq_alu dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Ctl(Ctl),
               .A(A), .B(B), .Shamt(Shamt), .out_valid(out_valid), .out_ready(out_ready),
               .Result(Result), .Zero(Zero));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [4:0]  s;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;
  vec_t v[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] s);
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  return b << s;
      4'd9:  return b >> s;
      4'd11: return b[31] ? ~((~b) >> s) : b >> s;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(logic [3:0] c, logic [4:0] s);
    return (!BARREL && (c == 4'd8 || c == 4'd9 || c == 4'd11) && s != 0) ? int'(s) + 1 : 1;
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, output int lat, output logic [31:0] r,
                        output logic z, output logic busy_ok);
    @(negedge clk);
    Ctl = c; A = a; B = b; Shamt = s; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    busy_ok = !in_ready;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) busy_ok = 0;
    end
    r = Result; z = Zero;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [31:0] r, held;
    logic z, bo;
    v.push_back('{4'd2,  32'd5,        32'd7,        5'd0,  32'd12,       1'b0, 1});
    v.push_back('{4'd6,  32'd3,        32'd3,        5'd0,  32'd0,        1'b1, 1});
    v.push_back('{4'd7,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0, 1});
    v.push_back('{4'd5,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1'b1, 1});
    v.push_back('{4'd4,  32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 1'b0, 1});
    v.push_back('{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5'd3,  32'hF000F000, 1'b0, 1});
    v.push_back('{4'd1,  32'h0000F000, 32'h0000000F, 5'd0,  32'h0000F00F, 1'b0, 1});
    v.push_back('{4'd3,  32'hAAAA5555, 32'hAAAA5555, 5'd0,  32'd0,        1'b1, 1});
    v.push_back('{4'd11, 32'd0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, 5});
    v.push_back('{4'd8,  32'd0,        32'h00000001, 5'd0,  32'h00000001, 1'b0, 1});
    v.push_back('{4'd9,  32'd0,        32'h80000000, 5'd31, 32'h00000001, 1'b0, 32});
    v.push_back('{4'd11, 32'd0,        32'h80000001, 5'd31, 32'hFFFFFFFF, 1'b0, 32});
    v.push_back('{4'd8,  32'd0,        32'h00000003, 5'd31, 32'h80000000, 1'b0, 32});
    v.push_back('{4'd10, 32'd5,        32'd9,        5'd2,  32'd0,        1'b1, 1});
    v.push_back('{4'd15, 32'd5,        32'd9,        5'd0,  32'd0,        1'b1, 1});

    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset Result", Result, 0);
    check("reset Zero", Zero, 0);
    @(negedge clk) rst = 0;

    foreach (v[i]) begin
      run_op(v[i].c, v[i].a, v[i].b, v[i].s, lat, r, z, bo);
      check($sformatf("vec%0d Result", i), r, v[i].r);
      check($sformatf("vec%0d Zero", i), z, v[i].z);
      check($sformatf("vec%0d latency", i), lat, BARREL ? 1 : v[i].lat);
      check($sformatf("vec%0d in_ready low while busy", i), bo, 1);
    end

    // backpressure: ADD held in DONE for 3 cycles
    @(negedge clk);
    Ctl = 4'd2; A = 32'd5; B = 32'd7; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp Result", Result, 32'd12);
      check("bp Zero", Zero, 0);
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    check("bp release out_valid", out_valid, 0);
    check("bp release in_ready", in_ready, 1);

    // async reset in the middle of a long shift
    @(negedge clk);
    Ctl = 4'd9; B = 32'h80000000; Shamt = 5'd31; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #2 rst = 1;
    #1;
    check("midshift rst out_valid", out_valid, 0);
    check("midshift rst Result", Result, 0);
    check("midshift rst in_ready", in_ready, 1);
    @(negedge clk) rst = 0;
    #1 check("post rst in_ready", in_ready, 1);
    run_op(4'd2, 32'd100, 32'd23, 5'd0, lat, r, z, bo);
    check("post rst ADD Result", r, 32'd123);
    check("post rst ADD latency", lat, 1);

    // random ops against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [3:0] c;
      logic [31:0] a, b;
      logic [4:0] s;
      c = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      s = 5'($urandom);
      if (n % 4 == 0) b = {1'b1, b[30:0]};
      run_op(c, a, b, s, lat, r, z, bo);
      check($sformatf("rand%0d ctl=%0d Result", n, c), r, ref_alu(c, a, b, s));
      check($sformatf("rand%0d Zero", n), z, ref_alu(c, a, b, s) == 0);
      check($sformatf("rand%0d latency", n), lat, ref_lat(c, s));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle execution unit at the consuming end of the 4-bit ALU control code produced by the ALU control decoder.
- Executes the decoded Ctl operation on operands A/B under a valid/ready handshake.
- Logic and arithmetic ops take 1 cycle; shifts run iteratively at 1 bit per cycle unless the barrel option is compiled in.
- Sits in the EX stage between the operand muxes and the EX/MEM result register.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHW, $clog2(WIDTH), shift-amount width (5 at default).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- Ctl  in  4  ALU control code.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; also the shifted operand.
- Shamt  in  SHW  shift amount. Upstream muxes this between the instr shamt field and A[SHW-1:0].
- out_valid  out  1  Result and Zero are valid.
- out_ready  in  1  consumer accepts the result.
- Result  out  WIDTH  registered result.
- Zero  out  1  registered (Result == 0).

Behaviour:
- Ctl codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR.
  - 0101 SLTU (unsigned A<B, result 1/0); 0110 SUB (A-B); 0111 SLT (signed A<B, result 1/0).
  - 1000 SLL; 1001 SRL; 1011 SRA (B shifted by Shamt).
  - All other codes (1010, 11xx): Result=0, Zero=1, 1-cycle latency.
- Arithmetic is modulo 2^WIDTH; no overflow detection, no trap.
- Reset (async, any cycle, including mid-shift):
  - state=IDLE; in_ready=1; out_valid=0; Result=0; Zero=0; shift counter=0.
  - Any in-flight op is discarded.
- FSM states IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE). Accept = in_valid && in_ready. Ctl/A/B/Shamt are sampled only on accept.
  - IDLE, accept, non-shift op: Result and Zero registered; next state DONE. out_valid rises the cycle after accept (latency 1).
  - IDLE, accept, shift op with Shamt==0: Result=B; next state DONE (latency 1).
  - IDLE, accept, shift op with Shamt>0: working register=B, counter=Shamt; next state SHIFT.
  - SHIFT: each cycle, working register shifts 1 bit (SLL zero-fill, SRL zero-fill, SRA sign-fill from bit WIDTH-1) and counter decrements. When counter==1 that cycle, next state DONE. out_valid asserts Shamt+1 cycles after accept.
  - DONE: out_valid=1. Result/Zero held stable until out_valid && out_ready. Next state IDLE; out_valid=0 next cycle.
  - No back-to-back accept in the DONE->IDLE transition cycle. Throughput is at most 1 op per 2 cycles.
- Zero is always registered in the same cycle as the final Result, never updated mid-shift.
- Inputs in SHIFT/DONE are ignored. in_valid may stay high without effect.
- Shamt=WIDTH-1 (31): SRA of a negative value yields all ones; SRL of any value yields 0 or 1.

Optional Feature:
- Macro: SEQ_ALU_BARREL_EN.
- Defined: shifts computed combinationally in one cycle, same latency 1 as other ops. SHIFT state and counter are not generated.
- Undefined: iterative shifting as described above.
- The Result for every Ctl/A/B/Shamt combination is identical in both builds; only latency differs.

Decomposition:
- Package seq_alu_pkg:
  - Ctl code localparams: CTL_AND, CTL_OR, CTL_ADD, CTL_XOR, CTL_NOR, CTL_SLTU, CTL_SUB, CTL_SLT, CTL_SLL, CTL_SRL, CTL_SRA.
  - State enum typedef alu_state_t {IDLE, SHIFT, DONE}.
  - is_shift() function.
- Sub-module alu_core: purely combinational non-shift ops (AND..SLT) giving a WIDTH-bit result. Instantiated once by seq_alu; the FSM and shifter stay in seq_alu.

Test Plan:
- ADD, A=5, B=7, out_ready=1 -> out_valid the next cycle, Result=12, Zero=0. SUB, A=3, B=3 -> Result=0, Zero=1.
- SLT, A=32'hFFFFFFFF, B=1 -> Result=1. SLTU with the same operands -> Result=0. NOR, A=0, B=0 -> Result=32'hFFFFFFFF.
- SRA, B=32'h80000000, Shamt=4 -> out_valid exactly 5 cycles after accept, Result=32'hF8000000, in_ready=0 throughout. With SEQ_ALU_BARREL_EN: 1 cycle, same Result.
- SLL, B=32'h1, Shamt=0 -> Result=32'h1 after 1 cycle. SRL, B=32'h80000000, Shamt=31 -> Result=1 after 32 cycles.
- Backpressure: ADD result with out_ready=0 for 3 cycles -> Result/Zero stable and out_valid=1 throughout, in_ready=0. out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
- Reset asserted asynchronously mid-SHIFT (Shamt=31, cycle 10) -> out_valid=0, Result=0 immediately. After rst deasserts, in_ready=1 and a new ADD completes normally.
